// File: rtl/aes_key_schedule_if.sv
// Key-load / round-key read bus between the cipher controller and the AES-128 key schedule.
// 128-bit vectors: byte 0 (first key byte) sits in the most significant byte [127:120].
interface aes_key_schedule_if;
    logic         key_load;
    logic [127:0] key_in;
    logic         busy;
    logic         key_ready;
    logic [3:0]   rk_addr;
    logic [127:0] rk_out;

    modport master (
        output key_load,
        output key_in,
        output rk_addr,
        input  busy,
        input  key_ready,
        input  rk_out
    );

    modport slave (
        input  key_load,
        input  key_in,
        input  rk_addr,
        output busy,
        output key_ready,
        output rk_out
    );
endinterface

// File: rtl/aes_key_schedule.sv
// AES-128 key schedule: one expansion round per clock into an 11-entry round-key store,
// with a registered read port. Contains the team byte S-box used four times for SubWord.

module s_box (
    input  logic [3:0] hi,
    input  logic [3:0] lo,
    output logic [7:0] y
);
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[{hi, lo}];
endmodule

// state  | meaning
// IDLE   | no key loaded since reset
// EXPAND | generating round keys 1..NR, one per clock
// DONE   | all round keys valid; a new key_load restarts expansion
module aes_key_schedule #(
    parameter int NR = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_key_schedule_if.slave   ks
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [127:0] rk_q [0:NR];
    logic [127:0] rk_d [0:NR];
    logic [127:0] prev_q, prev_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] rk_out_q, rk_out_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;
    logic         load, step;
    logic         busy, key_ready;

    assign w0 = prev_q[127:96];
    assign w1 = prev_q[95:64];
    assign w2 = prev_q[63:32];
    assign w3 = prev_q[31:0];

    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        s_box u_s_box (
            .hi (rot_w[8*b+7 -: 4]),
            .lo (rot_w[8*b+3 -: 4]),
            .y  (sub_w[8*b+7 -: 8])
        );
    end

    assign t_w      = sub_w ^ {rcon_q, 24'h000000};
    assign n0       = w0 ^ t_w;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // key_load is only honoured outside EXPAND; an expansion always runs to completion.
    assign load = ks.key_load && (state_q != EXPAND);
    assign step = (state_q == EXPAND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (ks.key_load) state_d = EXPAND;
            EXPAND:     if (round_q == 4'(NR)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        key_ready = 1'b0;
        case (state_q)
            EXPAND:  busy      = 1'b1;
            DONE:    key_ready = 1'b1;
            default: ;
        endcase
    end

    assign ks.busy      = busy;
    assign ks.key_ready = key_ready;

    always_comb begin
        prev_d  = prev_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        for (int i = 0; i <= NR; i++) rk_d[i] = rk_q[i];

        if (load) begin
            rk_d[0] = ks.key_in;
            prev_d  = ks.key_in;
            rcon_d  = 8'h01;
            round_d = 4'd1;
        end else if (step) begin
            for (int i = 1; i <= NR; i++) begin
                if (round_q == 4'(i)) rk_d[i] = next_key;
            end
            prev_d  = next_key;
            round_d = round_q + 4'd1;
            rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
    end

    // Reads see the store as it was before this edge's write (no bypass).
    always_comb begin
        rk_out_d = '0;
        for (int i = 0; i <= NR; i++) begin
            if (ks.rk_addr == 4'(i)) rk_out_d = rk_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            rcon_q   <= '0;
            round_q  <= '0;
            rk_out_q <= '0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            prev_q   <= prev_d;
            rcon_q   <= rcon_d;
            round_q  <= round_d;
            rk_out_q <= rk_out_d;
            for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
        end
    end

    assign ks.rk_out = rk_out_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 and all-zero key expansions, ignored loads,
// restart with stale reads, out-of-range reads and mid-expansion reset.
module tb_aes_key_schedule;
    typedef struct {
        logic [3:0]   addr;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t fips_tab [11];
    vec_t zero_tab [11];

    aes_key_schedule_if ks_if ();

    aes_key_schedule #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ks_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic read_check(input string name, input logic [3:0] addr, input logic [127:0] exp);
        @(negedge clk);
        ks_if.rk_addr = addr;
        @(negedge clk);
        check($sformatf("%s_rk%0d", name, addr), ks_if.rk_out, exp);
    endtask

    task automatic check_table(input string name, input bit zero_key);
        for (int i = 0; i < 11; i++) begin
            if (zero_key) read_check(name, zero_tab[i].addr, zero_tab[i].exp);
            else          read_check(name, fips_tab[i].addr, fips_tab[i].exp);
        end
    endtask

    task automatic run_fips(input string name, input bit inject);
        int lat;
        bit both;
        @(negedge clk);
        ks_if.key_in   = FIPS_KEY;
        ks_if.key_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ks_if.key_load = 1'b0;
        ks_if.key_in   = OTHER_KEY;
        check({name, "_busy_after_load"}, 128'(ks_if.busy), 128'd1);
        check({name, "_ready_after_load"}, 128'(ks_if.key_ready), 128'd0);
        lat  = -1;
        both = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            ks_if.key_load = inject && (c == 3 || c == 7);
            @(posedge clk);
            @(negedge clk);
            ks_if.key_load = 1'b0;
            if (ks_if.busy && ks_if.key_ready) both = 1'b1;
            if (ks_if.key_ready && lat < 0) lat = c;
        end
        check({name, "_latency"}, 128'(lat), 128'd10);
        check({name, "_busy_and_ready"}, 128'(both), 128'd0);
        check({name, "_busy_done"}, 128'(ks_if.busy), 128'd0);
        check_table(name, 1'b0);
    endtask

    initial begin
        fips_tab[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        fips_tab[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        fips_tab[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        fips_tab[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        fips_tab[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        fips_tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        fips_tab[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        fips_tab[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        fips_tab[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        fips_tab[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        fips_tab[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        zero_tab[0]  = '{4'd0,  128'h00000000000000000000000000000000};
        zero_tab[1]  = '{4'd1,  128'h62636363626363636263636362636363};
        zero_tab[2]  = '{4'd2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
        zero_tab[3]  = '{4'd3,  128'h90973450696ccffaf2f457330b0fac99};
        zero_tab[4]  = '{4'd4,  128'hee06da7b876a1581759e42b27e91ee2b};
        zero_tab[5]  = '{4'd5,  128'h7f2e2b88f8443e098dda7cbbf34b9290};
        zero_tab[6]  = '{4'd6,  128'hec614b851425758c99ff09376ab49ba7};
        zero_tab[7]  = '{4'd7,  128'h217517873550620bacaf6b3cc61bf09b};
        zero_tab[8]  = '{4'd8,  128'h0ef903333ba9613897060a04511dfa9f};
        zero_tab[9]  = '{4'd9,  128'hb1d4d8e28a7db9da1d7bb3de4c664941};
        zero_tab[10] = '{4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        ks_if.key_load = 1'b0;
        ks_if.key_in   = '0;
        ks_if.rk_addr  = '0;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ks_if.key_load = 1'($urandom_range(0, 1));
            ks_if.key_in   = {$urandom, $urandom, $urandom, $urandom};
            ks_if.rk_addr  = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            check($sformatf("reset_busy_%0d", i), 128'(ks_if.busy), 128'd0);
            check($sformatf("reset_ready_%0d", i), 128'(ks_if.key_ready), 128'd0);
            check($sformatf("reset_rkout_%0d", i), ks_if.rk_out, 128'd0);
        end
        @(negedge clk);
        ks_if.key_load = 1'b0;
        rst_n          = 1'b1;
        for (int a = 0; a <= 10; a++) read_check("post_reset", 4'(a), 128'd0);

        run_fips("fips", 1'b0);
        run_fips("fips_ignored_loads", 1'b1);

        // Restart from DONE with the zero key; stale and out-of-range reads during expansion.
        @(negedge clk);
        ks_if.key_in   = '0;
        ks_if.key_load = 1'b1;
        ks_if.rk_addr  = 4'd0;
        @(posedge clk);
        @(negedge clk);
        ks_if.key_load = 1'b0;
        check("restart_ready_drop", 128'(ks_if.key_ready), 128'd0);
        check("restart_busy", 128'(ks_if.busy), 128'd1);
        @(posedge clk);
        @(negedge clk);
        ks_if.rk_addr = 4'd5;
        @(posedge clk);
        @(negedge clk);
        check("restart_old_rk5", ks_if.rk_out, fips_tab[5].exp);
        ks_if.rk_addr = 4'd12;
        @(posedge clk);
        @(negedge clk);
        check("restart_addr12", ks_if.rk_out, 128'd0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("zero_ready", 128'(ks_if.key_ready), 128'd1);
        check("zero_busy", 128'(ks_if.busy), 128'd0);
        check_table("zero", 1'b1);
        read_check("zero_oob", 4'd15, 128'd0);

        // Reset in the middle of an expansion wipes everything.
        @(negedge clk);
        ks_if.key_in   = FIPS_KEY;
        ks_if.key_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ks_if.key_load = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 128'(ks_if.busy), 128'd0);
        check("midreset_ready", 128'(ks_if.key_ready), 128'd0);
        check("midreset_rkout", ks_if.rk_out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a <= 10; a++) read_check("midreset_store", 4'(a), 128'd0);
        run_fips("fips_after_reset", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential AES-128 key schedule controller. Accepts a 128-bit cipher key, iterates the one-round key-expansion step (RotWord, SubWord, Rcon XOR, word chaining) once per clock to produce round keys 0..10, and holds them in an internal round-key store. It sits directly upstream of the cipher round datapath, which reads one round key per round through a registered read port.

## Interface
Parameters:
- NR, 10: number of expansion rounds. Fixed for AES-128; other values are unsupported.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_load  input  1  single-cycle request to start expansion of key_in.
- key_in  input  128  cipher key. Bit 0 is the MSB; byte 0 occupies bits 0..7.
- busy  output  1  high while round keys 1..10 are being generated.
- key_ready  output  1  high when all 11 round keys are valid in the store.
- rk_addr  input  4  round-key index to read, 0..10.
- rk_out  output  128  registered round key selected by rk_addr. Same bit order as key_in.

## Operation
- States: IDLE (after reset), EXPAND, DONE.
- IDLE or DONE with key_load=1:
  - rk[0] <= key_in; prev <= key_in; rcon <= 0x01000000; round <= 1.
  - busy <= 1; key_ready <= 0; state goes to EXPAND.
- EXPAND, each edge:
  - Compute next = expand(prev, rcon):
    - t = SubWord(RotWord(w3)) ^ rcon.
    - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
    - w0..w3 are the 32-bit words of prev; w0 is bits 0..31.
  - rk[round] <= next; prev <= next; round <= round+1.
  - rcon byte <= xtime(rcon byte): shift left 1, XOR 0x1B if the MSB was set. Sequence is 01,02,04,08,10,20,40,80,1B,36.
  - When round==10: busy <= 0, key_ready <= 1, state goes to DONE.
- SubWord uses four instances of the team s_box (each takes a high nibble and a low nibble, returns a byte). No other S-box implementation is permitted.
- key_load while in EXPAND is ignored. There is no abort; the current expansion completes.
- key_load in DONE restarts expansion. key_ready drops on that edge, and old round keys are overwritten progressively.
- Read port: rk_out <= rk[rk_addr] on every edge, independent of state. rk_addr 11..15 gives rk_out <= 0.
- Reads during EXPAND are legal. They return whatever is stored: a new key, an old key, or zero after reset.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE, busy=0, key_ready=0, rk_out=0.
  - round=0, rcon=0, and all rk[0..10]=0.
- key_load sampled at edge T0: rk[0] is valid after T0, and busy=1 after T0.
- rk[n] is written at edge Tn for n=1..10.
- After T10: busy=0, key_ready=1. Total load-to-ready latency is 10 cycles.
- The earliest restart is key_load sampled at T11.
- Read latency is 1 cycle: rk_addr at edge E gives rk_out valid after E.
- Write and read of the same index on the same edge: rk_out returns the old contents (no bypass).
- rst_n asserted mid-EXPAND: everything returns to reset values immediately. No partial keys survive.
- busy and key_ready are never both high.

## Test plan
- Reset: hold rst_n=0 with random inputs.
  - busy=0, key_ready=0, rk_out=0.
  - Then read addresses 0..10 after release: all reads are 0.
- FIPS-197 key: key_in=2b7e151628aed2a6abf7158809cf4f3c, one key_load pulse.
  - key_ready rises exactly 10 cycles after the load edge.
  - rk[1]=a0fafe1788542cb123a339392a6c7605.
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - rk[1]=62636363626363636263636362636363.
  - rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
  - Confirms the rcon wrap 80->1B->36.
- key_load pulses at T3 and T7 during the FIPS expansion with a different key_in.
  - Pulses are ignored; results are identical to the FIPS case.
  - key_ready still rises at T10.
- Restart and read behaviour:
  - From DONE, load the zero key; key_ready falls on the load edge.
  - Read rk_addr=5 at T2: returns the old FIPS rk[5].
  - Read rk_addr=12: returns 0.
- Mid-operation reset: pulse rst_n=0 at T5 of an expansion.
  - All outputs and stored keys are 0.
  - A subsequent FIPS load produces correct keys.
